iot601x_reader: RTL
===================

IOT601X_READER -- requirements
Module: iot601x_reader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 0; fetch timeout in CLK cycles, 0 = never time out.
REQ-002 CLK  input  1  system clock, all state changes on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 CLEAR  input  1  synchronous, active-high device clear (CAF / front-panel clear).
REQ-005 EN  input  1  high when the current instruction is IOT 601x.
REQ-006 IR  input  3  IR[2:0] device function bits.
REQ-007 ck1..ck6  input  1 each  sequencer phase clocks, one-cycle pulses.
REQ-008 stb1..stb6  input  1 each  sequencer strobes, unused except stb2.
REQ-009 rxData  input  8  byte from upstream byte source.
REQ-010 rxValid  input  1  rxData valid.
REQ-011 rxReady  output  1  reader requests a byte; transfer when rxValid & rxReady.
REQ-012 done  output  1  instruction complete.
REQ-013 pc_ck  output  1  PC increment request (skip).
REQ-014 irq  output  1  interrupt request to CPU.
REQ-015 ACRDR  output  12  OR-bus contribution to AC, 0 when not driving.
REQ-016 rot2ac  output  1  enable ACC-path result onto AC input.
REQ-017 ac_ck  output  1  latch AC.

Function
REQ-018 All outputs are combinational decodes of EN, IR, ckN and internal state except rxReady and irq, which are registered or decoded from registers only.
REQ-019 Internal state: flag (1), ie (1), buffer (8), FSM {IDLE, FETCH}, timeout counter (24).
REQ-020 RSF (IR[0]): at ck1 with EN and flag=1 -> pc_ck=1 for that cycle.
REQ-021 RRB (IR[1]): at ck2 with EN -> ACRDR={4'b0,buffer}, rot2ac=1, ac_ck=1; flag cleared at stb2.
REQ-022 RFC (IR[2]): at ck3 with EN -> flag cleared, FSM to FETCH next cycle, counter zeroed.
REQ-023 RPE (IR=000): at ck3 with EN -> ie set to 1.
REQ-024 done=1 at ck3 whenever EN; functions combine (6016 = RRB then RFC in one instruction).
REQ-025 FETCH: rxReady=1; on rxValid -> buffer<=rxData, flag<=1, FSM to IDLE; flag visible the cycle after the transfer.
REQ-026 IDLE: rxReady=0; rxValid ignored, no byte consumed.
REQ-027 TIMEOUT_CYCLES>0: counter increments each FETCH cycle; reaching TIMEOUT_CYCLES -> IDLE, flag stays 0, buffer unchanged.
REQ-028 Simultaneous transfer and flag clear (RRB/RFC) in one cycle: set wins, flag=1.
REQ-029 RFC while already in FETCH: stay in FETCH, counter restarts.
REQ-030 irq = flag & ie.

Reset
REQ-031 RESET or CLEAR: flag=0, ie=1, buffer=0, FSM=IDLE, counter=0; rxReady=0, irq=0 next cycle.
REQ-032 RESET/CLEAR during FETCH aborts the fetch; a coincident rxValid byte is dropped.
REQ-033 RESET has priority over every function in the same cycle.

Configuration
REQ-034 Macro PR8_IRQ_EN defined: ie register and RPE exist as above.
REQ-035 Macro PR8_IRQ_EN undefined: no ie register, irq tied 0, RPE only asserts done.

Structure
REQ-036 IOT device codes (6010..6016) and FSM state encodings live in shared include pdp8_defs.vh.
REQ-037 One sub-module reader_fetch_fsm holds the FETCH/IDLE FSM, the timeout counter, the buffer and the handshake.

Verification
REQ-038 RFC, then rxData=8'h41 with rxValid 3 cycles later -> rxReady high until transfer, flag=1 next cycle, RSF at ck1 gives pc_ck=1.
REQ-039 AC=0, flag=1, buffer=8'hC5, 6012 -> ACRDR=12'o0305, ac_ck at ck2, flag=0 after stb2, done at ck3.
REQ-040 TIMEOUT_CYCLES=16, RFC, no rxValid -> rxReady drops after 16 cycles, flag=0, buffer unchanged.
REQ-041 rxValid transfer in the same cycle as the RRB flag clear -> flag=1 afterwards.
REQ-042 RESET mid-FETCH with rxValid=1 -> IDLE, buffer=0, flag=0, ie=1, irq=0.
REQ-043 PR8_IRQ_EN defined, flag set -> irq=1; CLEAR -> irq=0. Macro undefined -> irq stays 0 in all cases.

Source files
------------

// File: rtl/iot601x_reader_pkg.sv
// Shared constants for the IOT 601x paper-tape reader: bus widths, device
// function codes and the fetch FSM state encoding.
package iot601x_reader_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned AC_W   = 12;
   localparam int unsigned CNT_W  = 24;
   localparam int unsigned IR_W   = 3;

   // IOT device codes; the low IR_W bits select the device function.
   localparam logic [AC_W-1:0] IOT_RPE = 12'o6010;
   localparam logic [AC_W-1:0] IOT_RSF = 12'o6011;
   localparam logic [AC_W-1:0] IOT_RRB = 12'o6012;
   localparam logic [AC_W-1:0] IOT_RFC = 12'o6014;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } fetch_state_e;

   // Function-bit pattern of a full IOT code.
   function automatic logic [IR_W-1:0] iot_fn(input logic [AC_W-1:0] code);
      return code[IR_W-1:0];
   endfunction

endpackage

// File: rtl/iot601x_reader_if.sv
// Byte-stream handshake between an upstream byte source and the reader.
interface iot601x_reader_if;
   import iot601x_reader_pkg::*;

   logic [DATA_W-1:0] rxData;
   logic              rxValid;
   logic              rxReady;

   modport master (output rxData, output rxValid, input rxReady);
   modport slave  (input rxData, input rxValid, output rxReady);

endinterface

// File: rtl/iot601x_reader_fetch_fsm.sv
// Reader fetch engine: IDLE/FETCH FSM, optional fetch timeout, byte buffer
// and the rxValid/rxReady handshake.
module iot601x_reader_fetch_fsm
   import iot601x_reader_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   iot601x_reader_if.slave    rx,
   output logic [DATA_W-1:0]  o_buffer,
   output logic               o_xfer_c
);

   localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   fetch_state_e      r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [DATA_W-1:0] r_buf, w_buf_nxt;

   // Ready is a pure decode of the state register.
   assign rx.rxReady = (r_state == ST_FETCH);
   assign o_buffer   = r_buf;

   // State, counter and buffer registers; reset/clear aborts any fetch.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_buf   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_buf   <= w_buf_nxt;
      end
   end

   // Next-state: a restart request wins for state, a byte is always taken
   // when offered in FETCH, otherwise the timeout counter advances.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_buf_nxt   = r_buf;
      o_xfer_c    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_FETCH;
               w_cnt_nxt   = '0;
            end
         end
         ST_FETCH: begin
            if (rx.rxValid) begin
               o_xfer_c  = ~i_rst;
               w_buf_nxt = rx.rxData;
            end
            if (i_start) begin
               w_state_nxt = ST_FETCH;
               w_cnt_nxt   = '0;
            end else if (rx.rxValid) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (TO_EN && (r_cnt == TO_LAST)) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/iot601x_reader.sv
// IOT 601x paper-tape reader device: decodes RSF/RRB/RFC/RPE against the
// sequencer phases and keeps the reader flag and interrupt enable.
// Build option: define PR8_IRQ_EN to include the interrupt-enable register
// and RPE; otherwise irq is tied low and RPE only completes the instruction.
module iot601x_reader
   import iot601x_reader_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CLEAR,
   input  logic             EN,
   input  logic [IR_W-1:0]  IR,
   input  logic             ck1,
   input  logic             ck2,
   input  logic             ck3,
   input  logic             ck4,
   input  logic             ck5,
   input  logic             ck6,
   input  logic             stb1,
   input  logic             stb2,
   input  logic             stb3,
   input  logic             stb4,
   input  logic             stb5,
   input  logic             stb6,
   iot601x_reader_if.slave  rx,
   output logic             done,
   output logic             pc_ck,
   output logic             irq,
   output logic [AC_W-1:0]  ACRDR,
   output logic             rot2ac,
   output logic             ac_ck
);

   localparam logic [IR_W-1:0] FN_RSF = iot_fn(IOT_RSF);
   localparam logic [IR_W-1:0] FN_RRB = iot_fn(IOT_RRB);
   localparam logic [IR_W-1:0] FN_RFC = iot_fn(IOT_RFC);
   localparam logic [IR_W-1:0] FN_RPE = iot_fn(IOT_RPE);

   logic              w_rst;
   logic              w_rsf, w_rrb_ck, w_rrb_clr, w_rfc, w_rpe;
   logic              w_xfer_c;
   logic [DATA_W-1:0] w_buf;
   logic              r_flag;
   logic              w_unused_ok;

   assign w_rst     = RESET | CLEAR;
   assign w_rsf     = EN & (|(IR & FN_RSF)) & ck1;
   assign w_rrb_ck  = EN & (|(IR & FN_RRB)) & ck2;
   assign w_rrb_clr = EN & (|(IR & FN_RRB)) & stb2;
   assign w_rfc     = EN & (|(IR & FN_RFC)) & ck3;
   assign w_rpe     = EN & (IR == FN_RPE) & ck3;

   // Phases and strobes the reader does not act on.
   assign w_unused_ok = &{1'b0, ck4, ck5, ck6, stb1, stb3, stb4, stb5, stb6};

   iot601x_reader_fetch_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_fetch (
      .i_clk    (CLK),
      .i_rst    (w_rst),
      .i_start  (w_rfc),
      .rx       (rx),
      .o_buffer (w_buf),
      .o_xfer_c (w_xfer_c)
   );

   // Reader flag: a completed transfer beats a same-cycle RRB/RFC clear.
   always_ff @(posedge CLK) begin
      if (w_rst)
         r_flag <= 1'b0;
      else if (w_xfer_c)
         r_flag <= 1'b1;
      else if (w_rrb_clr | w_rfc)
         r_flag <= 1'b0;
   end

`ifdef PR8_IRQ_EN
   logic r_ie;

   // Interrupt enable: set by reset/clear and by RPE.
   always_ff @(posedge CLK) begin
      if (w_rst)
         r_ie <= 1'b1;
      else if (w_rpe)
         r_ie <= 1'b1;
   end

   assign irq = r_flag & r_ie;
`else
   logic w_unused_rpe;

   assign w_unused_rpe = w_rpe;
   assign irq          = 1'b0;
`endif

   assign pc_ck  = w_rsf & r_flag;
   assign ACRDR  = w_rrb_ck ? AC_W'(w_buf) : '0;
   assign rot2ac = w_rrb_ck;
   assign ac_ck  = w_rrb_ck;
   assign done   = EN & ck3;

endmodule
